bcd_display_scanner: RTL

- Downstream consumer of the binary-to-BCD converter. Captures four BCD digits (thousands..units) on a load strobe.
- Drives a 4-digit multiplexed 7-segment display: time-multiplexed anode scan, per-slot ghost blanking, leading-zero suppression and per-digit decimal points.
- Frame-synchronous update: a new value never tears mid-frame.

---
 rtl/seven_seg_pkg.sv | 29 ++
 rtl/bcd_to_7seg.sv | 34 +++
 rtl/bcd_display_scanner.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seven_seg_pkg : segment patterns, scanner states, index type    |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package seven_seg_pkg;

    // Active-high patterns ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef logic [1:0] state_t;
    localparam state_t ST_OFF   = 2'd0;
    localparam state_t ST_BLANK = 2'd1;
    localparam state_t ST_SHOW  = 2'd2;

    typedef logic [1:0] digit_idx_t;

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | bcd_to_7seg : BCD code to active-high segment pattern           |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module bcd_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | bcd_display_scanner : 4-digit multiplexed 7-seg display driver  |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module bcd_display_scanner
    import seven_seg_pkg::*;
#(
    parameter int PRESCALE_DIV   = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] bcd_thousands,
    input  logic [3:0] bcd_hundreds,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_units,
    input  logic [3:0] dp_in,
    input  logic       enable,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int               CNT_W    = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic             DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [3:0]       AN_OFF   = {4{AN_ACTIVE_LOW}};

    state_t           state, state_nx;
    digit_idx_t       idx, idx_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic [15:0] shadow_digits, disp_digits, view_digits;
    logic [3:0]  shadow_dp, disp_dp, view_dp;
    logic        pending;
    logic        transfer;

    logic [3:0]  cur_code;
    logic        cur_dp;
    logic        lead_zero;
    logic [6:0]  pattern;
    logic        show;
    logic [3:0]  an_act;
    logic [6:0]  seg_act;
    logic        dp_act;
    logic        fs_nx;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        if (!enable) begin
            state_nx = ST_OFF;
            idx_nx   = 2'd0;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nx = ST_BLANK;
                    idx_nx   = 2'd0;
                    cnt_nx   = '0;
                end
                ST_BLANK: begin
                    state_nx = ST_SHOW;
                    cnt_nx   = CNT_W'(1);
                end
                ST_SHOW: begin
                    if (cnt == CNT_LAST) begin
                        state_nx = ST_BLANK;
                        cnt_nx   = '0;
                        idx_nx   = idx + 2'd1;
                    end else begin
                        cnt_nx   = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = ST_OFF;
                    idx_nx   = 2'd0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // The slot-0 BLANK cycle is the only place a frame may pick up new data;
    // the SHOW registers loaded at its closing edge must already see it.
    assign transfer    = (state == ST_BLANK) && (idx == 2'd0) && pending;
    assign view_digits = transfer ? shadow_digits : disp_digits;
    assign view_dp     = transfer ? shadow_dp     : disp_dp;

    always_comb begin
        cur_code  = view_digits[3:0];
        cur_dp    = view_dp[0];
        lead_zero = 1'b0;
        case (idx_nx)
            2'd0: begin
                cur_code  = view_digits[3:0];
                cur_dp    = view_dp[0];
                lead_zero = 1'b0;
            end
            2'd1: begin
                cur_code  = view_digits[7:4];
                cur_dp    = view_dp[1];
                lead_zero = (view_digits[15:4] == 12'h000);
            end
            2'd2: begin
                cur_code  = view_digits[11:8];
                cur_dp    = view_dp[2];
                lead_zero = (view_digits[15:8] == 8'h00);
            end
            default: begin
                cur_code  = view_digits[15:12];
                cur_dp    = view_dp[3];
                lead_zero = (view_digits[15:12] == 4'h0);
            end
        endcase
    end

    bcd_to_7seg u_decode (
        .code    (cur_code),
        .blank   (BLANK_LEADING && lead_zero),
        .pattern (pattern)
    );

    assign show    = (state_nx == ST_SHOW);
    assign an_act  = show ? (4'b0001 << idx_nx) : 4'b0000;
    assign seg_act = show ? pattern : SEG_BLANK;
    assign dp_act  = show && cur_dp;
    assign fs_nx   = (state_nx == ST_BLANK) && (idx_nx == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_OFF;
            idx           <= 2'd0;
            cnt           <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            disp_digits   <= '0;
            disp_dp       <= '0;
            pending       <= 1'b0;
            an            <= AN_OFF;
            seg           <= SEG_OFF;
            dp            <= DP_OFF;
            frame_start   <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
            if (transfer) begin
                disp_digits <= shadow_digits;
                disp_dp     <= shadow_dp;
                pending     <= 1'b0;
            end
            // A load in the transfer cycle overrides the clear of pending
            if (load) begin
                shadow_digits <= {bcd_thousands, bcd_hundreds, bcd_tens, bcd_units};
                shadow_dp     <= dp_in;
                pending       <= 1'b1;
            end
            an          <= an_act  ^ AN_OFF;
            seg         <= seg_act ^ SEG_OFF;
            dp          <= dp_act  ^ DP_OFF;
            frame_start <= fs_nx;
        end
    end

endmodule
`default_nettype wire
